// File: rtl/dct_pkg.sv
// Shared constants for the DCT zigzag/quantise block.
//   state_t      : emitter states (IDLE, EMIT)
//   QUANT_SHIFT  : fixed-point scale of the reciprocal table (2^15)
//   ZIGZAG       : JPEG zigzag order expressed as raster indices (r*8+c)
//   QUANT_RECIP  : round(32768/Q) of the JPEG luminance table, raster order
package dct_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  localparam int QUANT_SHIFT = 15;

  localparam logic [5:0] ZIGZAG [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  localparam logic [15:0] QUANT_RECIP [64] = '{
    16'd2048, 16'd2979, 16'd3277, 16'd2048, 16'd1365, 16'd819,  16'd643,  16'd537,
    16'd2731, 16'd2731, 16'd2341, 16'd1725, 16'd1260, 16'd565,  16'd546,  16'd596,
    16'd2341, 16'd2521, 16'd2048, 16'd1365, 16'd819,  16'd575,  16'd475,  16'd585,
    16'd2341, 16'd1928, 16'd1489, 16'd1130, 16'd643,  16'd377,  16'd410,  16'd529,
    16'd1820, 16'd1489, 16'd886,  16'd585,  16'd482,  16'd301,  16'd318,  16'd426,
    16'd1365, 16'd936,  16'd596,  16'd512,  16'd405,  16'd315,  16'd290,  16'd356,
    16'd669,  16'd512,  16'd420,  16'd377,  16'd318,  16'd271,  16'd273,  16'd324,
    16'd455,  16'd356,  16'd345,  16'd334,  16'd293,  16'd328,  16'd318,  16'd331
  };

endpackage

// File: rtl/dct_quant_round.sv
// Combinational quantiser: scale, round to nearest (ties away from zero),
// saturate to the signed OUT_WIDTH range.
// Build option DCT_ZZ_QUANT_EN: when defined, x is multiplied by
// QUANT_RECIP[raster] and shifted by FRAC_BITS+15; when undefined the
// multiplier and table are omitted and x is shifted by FRAC_BITS only.
// Ports:
//   x      : signed fixed-point coefficient (FRAC_BITS fractional bits)
//   raster : raster position of x, selects the reciprocal
//   y      : signed quantised result
module dct_quant_round
  import dct_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FRAC_BITS  = 16,
  parameter int OUT_WIDTH  = 16
) (
  input  logic [DATA_WIDTH-1:0] x,
  input  logic [5:0]            raster,
  output logic [OUT_WIDTH-1:0]  y
);

`ifdef DCT_ZZ_QUANT_EN
  localparam int PROD_W = DATA_WIDTH + 16;
  localparam int SHIFT  = FRAC_BITS + QUANT_SHIFT;

  logic signed [PROD_W-1:0] x_ext;
  logic signed [PROD_W-1:0] recip_ext;
  logic signed [PROD_W-1:0] prod;

  assign x_ext     = PROD_W'($signed(x));
  // Reciprocals are positive; the leading zero keeps them so when signed.
  assign recip_ext = PROD_W'($signed({1'b0, QUANT_RECIP[raster]}));
  assign prod      = x_ext * recip_ext;
`else
  localparam int PROD_W = DATA_WIDTH;
  localparam int SHIFT  = FRAC_BITS;

  logic signed [PROD_W-1:0] prod;
  logic                     unused_raster;

  assign prod          = $signed(x);
  assign unused_raster = ^raster;
`endif

  localparam logic [PROD_W:0] HALF    = (PROD_W+1)'(1) << (SHIFT - 1);
  localparam logic [PROD_W:0] POS_LIM = (PROD_W+1)'((64'd1 << (OUT_WIDTH - 1)) - 64'd1);
  localparam logic [PROD_W:0] NEG_LIM = (PROD_W+1)'(1) << (OUT_WIDTH - 1);

  logic            neg;
  logic [PROD_W:0] mag;
  logic [PROD_W:0] rnd;

  // Round the magnitude half-up, then restore the sign: this gives
  // ties-away-from-zero symmetrically. One extra bit keeps |min| exact.
  assign neg = prod[PROD_W-1];
  assign mag = neg ? -{prod[PROD_W-1], prod} : {prod[PROD_W-1], prod};
  assign rnd = (mag + HALF) >> SHIFT;

  always_comb begin
    y = '0;
    if (neg) begin
      if (rnd > NEG_LIM) y = {1'b1, {(OUT_WIDTH-1){1'b0}}};
      else               y = OUT_WIDTH'(-rnd);
    end else begin
      if (rnd > POS_LIM) y = {1'b0, {(OUT_WIDTH-1){1'b1}}};
      else               y = OUT_WIDTH'(rnd);
    end
  end

endmodule

// File: rtl/dct_zigzag_quant.sv
// Captures an 8x8 DCT block and streams it out in JPEG zigzag order, one
// quantised coefficient per accepted beat (valid/ready on both sides).
// A new block may be captured in the same cycle the last coefficient of the
// current block is accepted, so consecutive blocks stream without a bubble.
// Build option DCT_ZZ_QUANT_EN: enables table quantisation in
// dct_quant_round; otherwise coefficients are only rounded and saturated.
// Ports:
//   clk, reset_n      : clock, asynchronous active-low reset
//   in_valid/in_ready : input block handshake
//   data_in_matrix    : 64 coefficients, element (r,c) at (r*8+c)*DATA_WIDTH
//   out_valid/out_ready : output coefficient handshake
//   coeff_out         : signed quantised coefficient
//   coeff_index       : zigzag position 0..63
//   block_last        : high with zigzag position 63
module dct_zigzag_quant
  import dct_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FRAC_BITS  = 16,
  parameter int OUT_WIDTH  = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_WIDTH*64-1:0] data_in_matrix,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUT_WIDTH-1:0]     coeff_out,
  output logic [5:0]               coeff_index,
  output logic                     block_last
);

  state_t                state_reg, state_next;
  logic [5:0]            idx_reg, idx_next;
  logic [DATA_WIDTH-1:0] buf_mem [64];
  logic [DATA_WIDTH-1:0] matrix_word [64];
  logic                  emit;
  logic                  capture;
  logic [5:0]            raster;
  logic [OUT_WIDTH-1:0]  q_value;

  for (genvar gi = 0; gi < 64; gi++) begin : g_slice
    assign matrix_word[gi] = data_in_matrix[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  assign emit     = (state_reg == EMIT);
  assign in_ready = !emit || (idx_reg == 6'd63 && out_ready);
  assign capture  = in_valid && in_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 64; i++) buf_mem[i] <= '0;
    end else if (capture) begin
      for (int i = 0; i < 64; i++) buf_mem[i] <= matrix_word[i];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          state_next = EMIT;
          idx_next   = '0;
        end
      end
      EMIT: begin
        if (out_ready) begin
          if (idx_reg == 6'd63) begin
            // in_ready is high here, so in_valid means a capture this cycle
            state_next = in_valid ? EMIT : IDLE;
            idx_next   = '0;
          end else begin
            idx_next = idx_reg + 6'd1;
          end
        end
      end
      default: begin
        state_next = IDLE;
        idx_next   = '0;
      end
    endcase
  end

  assign raster = ZIGZAG[idx_reg];

  dct_quant_round #(
    .DATA_WIDTH(DATA_WIDTH),
    .FRAC_BITS (FRAC_BITS),
    .OUT_WIDTH (OUT_WIDTH)
  ) u_quant (
    .x     (buf_mem[raster]),
    .raster(raster),
    .y     (q_value)
  );

  // Outputs are functions of registered state only, so they hold during
  // stalls and drop to zero the instant reset asserts.
  assign out_valid   = emit;
  assign coeff_out   = emit ? q_value : '0;
  assign coeff_index = emit ? idx_reg : '0;
  assign block_last  = emit && (idx_reg == 6'd63);

endmodule
